chime_scheduler: RTL and testbench

Owns the single annunciator LED and shares it between the hourly chime (strike count) and the alarm (ring, snooze, stop). It runs on the 1 Hz time-base clock and samples the hour/minute/second counters. Requests are arbitrated with alarm priority. Set mode silences and aborts all activity.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/chime_scheduler_if.sv | 36 +++
 rtl/event_timer.sv | 27 ++
 rtl/chime_scheduler.sv | 161 ++++++++++++++++
 tb/tb_chime_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the annunciator scheduler.
// Holds the FSM state encoding and the hour-to-strike mapping.
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STRIKE_ON,
        STRIKE_OFF,
        RING,
        SNOOZE
    } state_t;

    localparam int HOURS_PER_DAY = 24;
    localparam int MAX_STRIKES   = 12;

    function automatic logic [3:0] strike_count(
        input logic [5:0] hour
    );
        logic [5:0] m;
        m = hour % 6'd12;
        return (m == 6'd0) ? 4'(MAX_STRIKES) : m[3:0];
    endfunction

endpackage

// File: rtl/chime_scheduler_if.sv
// Time inputs, user requests and annunciator outputs
// shared between the scheduler and its surroundings.
interface chime_scheduler_if;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       chime_en;
    logic       alarm_en;
    logic [5:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       snooze;
    logic       stop;
    logic       set_mode;
    logic       LED;
    logic       chime_active;
    logic       alarm_active;
    logic [3:0] strikes_left;

    modport master (
        output hour, minute, second,
        output chime_en, alarm_en,
        output alarm_hour, alarm_minute,
        output snooze, stop, set_mode,
        input  LED, chime_active,
        input  alarm_active, strikes_left
    );

    modport slave (
        input  hour, minute, second,
        input  chime_en, alarm_en,
        input  alarm_hour, alarm_minute,
        input  snooze, stop, set_mode,
        output LED, chime_active,
        output alarm_active, strikes_left
    );
endinterface

// File: rtl/event_timer.sv
// Loadable down-counter with zero flag, shared by the
// ring and snooze intervals. Load wins over decrement.
module event_timer #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && !zero)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/chime_scheduler.sv
// Shares the annunciator LED between the hourly chime
// and the alarm; the alarm always wins a collision.
module chime_scheduler
    import clock_pkg::*;
#(
    parameter int ALARM_SECS  = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int CNT_W       = 9
) (
    input logic         clk_1Hz,
    input logic         rst_n,
    chime_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] RING_LD =
        CNT_W'(ALARM_SECS - 1);
    localparam logic [CNT_W-1:0] SNZ_LD =
        CNT_W'(SNOOZE_SECS - 1);

    state_t     state;
    state_t     nxt;
    logic       led;
    logic       chime_act;
    logic       alarm_act;
    logic [3:0] sl;
    logic       chime_hit;
    logic       alarm_hit;
    logic       ld;
    logic [CNT_W-1:0] ld_val;
    logic       tmr_en;
    logic       zero;

    always_comb begin
        chime_hit = bus.chime_en
                 && bus.minute == 6'd0
                 && bus.second == 6'd0
                 && bus.hour < 6'(HOURS_PER_DAY)
                 && !bus.set_mode;
        alarm_hit = bus.alarm_en
                 && bus.hour == bus.alarm_hour
                 && bus.minute == bus.alarm_minute
                 && bus.second == 6'd0
                 && !bus.set_mode;
    end

    // Next state and timer loads; set mode overrides all.
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = '0;
        if (bus.set_mode) begin
            nxt = IDLE;
            ld  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (alarm_hit) begin
                        nxt    = RING;
                        ld     = 1'b1;
                        ld_val = RING_LD;
                    end else if (chime_hit) begin
                        nxt = STRIKE_ON;
                    end
                end
                STRIKE_ON, STRIKE_OFF: begin
                    if (alarm_hit) begin
                        nxt    = RING;
                        ld     = 1'b1;
                        ld_val = RING_LD;
                    end else if (state == STRIKE_ON) begin
                        nxt = STRIKE_OFF;
                    end else if (sl <= 4'd1) begin
                        nxt = IDLE;
                    end else begin
                        nxt = STRIKE_ON;
                    end
                end
                RING: begin
                    if (!bus.alarm_en || bus.stop) begin
                        nxt = IDLE;
                        ld  = 1'b1;
                    end else if (bus.snooze) begin
                        nxt    = SNOOZE;
                        ld     = 1'b1;
                        ld_val = SNZ_LD;
                    end else if (zero) begin
                        nxt = IDLE;
                    end
                end
                SNOOZE: begin
                    if (!bus.alarm_en || bus.stop) begin
                        nxt = IDLE;
                        ld  = 1'b1;
                    end else if (alarm_hit || zero) begin
                        nxt    = RING;
                        ld     = 1'b1;
                        ld_val = RING_LD;
                    end
                end
                default: begin
                    nxt = IDLE;
                    ld  = 1'b1;
                end
            endcase
        end
    end

    assign tmr_en = (state == RING) || (state == SNOOZE);

    event_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk_1Hz),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val (ld_val),
        .en       (tmr_en),
        .zero     (zero)
    );

    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            state     <= IDLE;
            led       <= 1'b0;
            sl        <= 4'd0;
            chime_act <= 1'b0;
            alarm_act <= 1'b0;
        end else begin
            state     <= nxt;
            chime_act <= (nxt == STRIKE_ON)
                      || (nxt == STRIKE_OFF);
            alarm_act <= (nxt == RING)
                      || (nxt == SNOOZE);
            unique case (1'b1)
                nxt == STRIKE_ON: begin
                    led <= 1'b1;
                    sl  <= (state == IDLE)
                         ? strike_count(bus.hour)
                         : sl - 4'd1;
                end
                nxt == STRIKE_OFF: begin
                    led <= 1'b0;
                end
                nxt == RING: begin
                    led <= !(state == RING && led);
                    sl  <= 4'd0;
                end
                default: begin
                    led <= 1'b0;
                    sl  <= 4'd0;
                end
            endcase
        end
    end

    assign bus.LED          = led;
    assign bus.chime_active = chime_act;
    assign bus.alarm_active = alarm_act;
    assign bus.strikes_left = sl;

endmodule

// File: tb/tb_chime_scheduler.sv
// Scoreboard bench: stimulus queues the expected outputs
// for each edge, a monitor pops and compares after it.
module tb_chime_scheduler;

    logic clk;
    logic rst_n;

    chime_scheduler_if bus();

    chime_scheduler #(
        .ALARM_SECS  (4),
        .SNOOZE_SECS (3),
        .CNT_W       (9)
    ) dut (
        .clk_1Hz (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic       led;
        logic       ca;
        logic       aa;
        logic [3:0] sl;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.LED !== e.led
                    || bus.chime_active !== e.ca
                    || bus.alarm_active !== e.aa
                    || bus.strikes_left !== e.sl) begin
                    errors++;
                    $display(
                      "FAIL %s: got LED=%0b ca=%0b aa=%0b sl=%0d, want LED=%0b ca=%0b aa=%0b sl=%0d",
                      e.tag, bus.LED, bus.chime_active,
                      bus.alarm_active, bus.strikes_left,
                      e.led, e.ca, e.aa, e.sl);
                end
            end
        end
    end

    task automatic cyc(
        input logic       led,
        input logic       ca,
        input logic       aa,
        input logic [3:0] sl,
        input string      tag
    );
        exp_t e;
        e.led = led;
        e.ca  = ca;
        e.aa  = aa;
        e.sl  = sl;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic at(
        input logic [5:0] h,
        input logic [5:0] m,
        input logic [5:0] s
    );
        bus.hour   = h;
        bus.minute = m;
        bus.second = s;
    endtask

    task automatic alarm(
        input logic [5:0] h,
        input logic [5:0] m
    );
        bus.alarm_hour   = h;
        bus.alarm_minute = m;
        bus.alarm_en     = 1'b1;
    endtask

    task automatic chime(
        input logic [5:0] h,
        input int         n,
        input bit         drop_en
    );
        at(h, 6'd0, 6'd0);
        cyc(1, 1, 0, 4'(n), "strike_first");
        bus.second = 6'd1;
        if (drop_en)
            bus.chime_en = 1'b0;
        for (int k = n; k >= 1; k--) begin
            if (k != n)
                cyc(1, 1, 0, 4'(k), "strike_on");
            cyc(0, 1, 0, 4'(k), "strike_off");
        end
        cyc(0, 0, 0, 4'd0, "chime_done");
        bus.chime_en = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.snooze   = 1'b0;
        bus.stop     = 1'b0;
        bus.set_mode = 1'b0;
        bus.chime_en = 1'b1;
        alarm(6'd0, 6'd0);
        at(6'd0, 6'd0, 6'd0);

        cyc(0, 0, 0, 4'd0, "reset_1");
        cyc(0, 0, 0, 4'd0, "reset_2");
        bus.second   = 6'd1;
        bus.alarm_en = 1'b0;
        rst_n = 1'b1;
        cyc(0, 0, 0, 4'd0, "idle_after_reset");

        chime(6'd3, 3, 1'b0);
        chime(6'd0, 12, 1'b1);
        chime(6'd13, 1, 1'b0);
        at(6'd8, 6'd38, 6'd0);
        cyc(0, 0, 0, 4'd0, "no_chime_0838");
        at(6'd30, 6'd0, 6'd0);
        cyc(0, 0, 0, 4'd0, "no_chime_hour30");
        bus.chime_en = 1'b0;
        at(6'd5, 6'd0, 6'd0);
        cyc(0, 0, 0, 4'd0, "chime_disabled");
        bus.second = 6'd1;

        alarm(6'd7, 6'd30);
        at(6'd7, 6'd30, 6'd0);
        cyc(1, 0, 1, 4'd0, "ring_1");
        bus.second = 6'd1;
        cyc(0, 0, 1, 4'd0, "ring_2");
        bus.snooze = 1'b1;
        cyc(0, 0, 1, 4'd0, "snooze_1");
        bus.snooze = 1'b0;
        cyc(0, 0, 1, 4'd0, "snooze_2");
        bus.snooze = 1'b1;
        cyc(0, 0, 1, 4'd0, "snooze_3_ignored");
        bus.snooze = 1'b0;
        cyc(1, 0, 1, 4'd0, "rering_1");
        cyc(0, 0, 1, 4'd0, "rering_2");
        cyc(1, 0, 1, 4'd0, "rering_3");
        cyc(0, 0, 1, 4'd0, "rering_4");
        cyc(0, 0, 0, 4'd0, "ring_expired");

        bus.chime_en = 1'b1;
        alarm(6'd6, 6'd0);
        at(6'd6, 6'd0, 6'd0);
        cyc(1, 0, 1, 4'd0, "collision_ring");
        bus.second = 6'd1;
        cyc(0, 0, 1, 4'd0, "collision_ring_2");
        at(6'd7, 6'd0, 6'd0);
        cyc(1, 0, 1, 4'd0, "chime_dropped");
        bus.second = 6'd1;
        bus.stop   = 1'b1;
        cyc(0, 0, 0, 4'd0, "stop_ring");
        bus.stop = 1'b0;
        cyc(0, 0, 0, 4'd0, "chime_not_queued");

        alarm(6'd5, 6'd30);
        at(6'd5, 6'd0, 6'd0);
        cyc(1, 1, 0, 4'd5, "abandon_strike");
        bus.second = 6'd1;
        bus.stop   = 1'b1;
        cyc(0, 1, 0, 4'd5, "stop_ignored_strike");
        bus.stop = 1'b0;
        at(6'd5, 6'd30, 6'd0);
        cyc(1, 0, 1, 4'd0, "abandon_ring");
        bus.second = 6'd1;
        cyc(0, 0, 1, 4'd0, "abandon_ring_2");
        bus.alarm_en = 1'b0;
        cyc(0, 0, 0, 4'd0, "alarm_disarmed");

        at(6'd5, 6'd0, 6'd0);
        cyc(1, 1, 0, 4'd5, "set_strike_1");
        bus.second = 6'd1;
        cyc(0, 1, 0, 4'd5, "set_strike_1_off");
        cyc(1, 1, 0, 4'd4, "set_strike_2");
        bus.set_mode = 1'b1;
        cyc(0, 0, 0, 4'd0, "setmode_strike");
        alarm(6'd6, 6'd0);
        at(6'd6, 6'd0, 6'd0);
        cyc(0, 0, 0, 4'd0, "setmode_blocks");
        bus.set_mode = 1'b0;
        bus.second   = 6'd1;
        cyc(0, 0, 0, 4'd0, "after_setmode");

        alarm(6'd9, 6'd15);
        at(6'd9, 6'd15, 6'd0);
        cyc(1, 0, 1, 4'd0, "snz_set_ring");
        bus.second = 6'd1;
        bus.snooze = 1'b1;
        cyc(0, 0, 1, 4'd0, "snz_set_snooze");
        bus.snooze = 1'b0;
        cyc(0, 0, 1, 4'd0, "snz_set_snooze_2");
        bus.set_mode = 1'b1;
        cyc(0, 0, 0, 4'd0, "setmode_snooze");
        bus.set_mode = 1'b0;
        cyc(0, 0, 0, 4'd0, "after_setmode_2");

        at(6'd9, 6'd15, 6'd0);
        cyc(1, 0, 1, 4'd0, "retrig_ring");
        bus.second = 6'd1;
        bus.snooze = 1'b1;
        cyc(0, 0, 1, 4'd0, "retrig_snooze");
        bus.snooze = 1'b0;
        at(6'd9, 6'd15, 6'd0);
        cyc(1, 0, 1, 4'd0, "retrig_in_snooze");
        bus.second = 6'd1;
        bus.snooze = 1'b1;
        cyc(0, 0, 1, 4'd0, "retrig_snooze_2");
        bus.snooze = 1'b0;
        bus.stop   = 1'b1;
        cyc(0, 0, 0, 4'd0, "stop_snooze");
        bus.stop = 1'b0;

        at(6'd9, 6'd15, 6'd0);
        cyc(1, 0, 1, 4'd0, "pre_reset_ring");
        bus.second = 6'd1;
        rst_n = 1'b0;
        cyc(0, 0, 0, 4'd0, "reset_mid_ring");
        rst_n = 1'b1;
        cyc(0, 0, 0, 4'd0, "post_reset");
        cyc(0, 0, 0, 4'd0, "post_reset_2");

        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, want 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
